// File: rtl/rle_pkg.sv
// Shared types and widths for the RLE job scheduler: FSM states, operand
// widths and the queued job descriptor layout.
package rle_pkg;

  localparam int ADDR_W = 32;
  localparam int SEQ_W  = 8;
  localparam int JOB_W  = 3 * ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4,
    ST_HALT   = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] msg_addr;
    logic [ADDR_W-1:0] msg_size;
    logic [ADDR_W-1:0] rle_addr;
  } job_t;

  // Empty jobs are answered directly without touching the engine.
  function automatic logic is_empty_job(input job_t job);
    return (job.msg_size == ADDR_ZERO);
  endfunction

endpackage

// File: rtl/rle_job_fifo.sv
// Job descriptor FIFO with a registered occupancy count and registered
// full/empty flags; a simultaneous push and pop is legal when full.
module rle_job_fifo #(
  parameter int JOB_DEPTH = 4,
  parameter int WIDTH     = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_full,
  output logic             not_empty
);

  localparam int AW = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
  localparam int CW = $clog2(JOB_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(JOB_DEPTH);

  logic [WIDTH-1:0] mem_r [JOB_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && (count_r != {CW{1'b0}});
  assign do_push_s = push && ((count_r < DEPTH_C) || do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1'b1);
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - CW'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, count and the registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      not_full  <= 1'b1;
      not_empty <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r   <= count_nxt_s;
      not_full  <= (count_nxt_s < DEPTH_C);
      not_empty <= (count_nxt_s != {CW{1'b0}});
    end
  end

endmodule

// File: rtl/rle_job_sched.sv
// Queues RLE compression jobs, launches them one at a time on the engine,
// supervises each with a watchdog and reports sized, sequenced results.
module rle_job_sched
  import rle_pkg::*;
#(
  parameter int JOB_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_msg_addr,
  input  logic [ADDR_W-1:0] job_msg_size,
  input  logic [ADDR_W-1:0] job_rle_addr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_rle_size,
  output logic              res_err,
  output logic [SEQ_W-1:0]  res_seq,
  output logic              rle_start,
  output logic [ADDR_W-1:0] rle_message_addr,
  output logic [ADDR_W-1:0] rle_message_size,
  output logic [ADDR_W-1:0] rle_rle_addr,
  input  logic              rle_done,
  input  logic [ADDR_W-1:0] rle_size,
  output logic              busy,
  output logic              halted
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_e    state_r;
  logic [WD_W-1:0] wd_r;
  job_t            head_s;
  job_t            push_job_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_not_empty_s;

  assign push_s     = job_valid && job_ready;
  assign push_job_s = '{msg_addr: job_msg_addr, msg_size: job_msg_size, rle_addr: job_rle_addr};
  assign pop_s      = (state_r == ST_IDLE) && fifo_not_empty_s;

  rle_job_fifo #(
    .JOB_DEPTH (JOB_DEPTH),
    .WIDTH     (JOB_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_job_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .not_full  (job_ready),
    .not_empty (fifo_not_empty_s)
  );

  // Scheduler FSM with all outputs registered; operands only load in IDLE,
  // so they stay frozen while the engine compares against them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      wd_r             <= {WD_W{1'b0}};
      rle_start        <= 1'b0;
      res_valid        <= 1'b0;
      res_err          <= 1'b0;
      res_rle_size     <= ADDR_ZERO;
      res_seq          <= {SEQ_W{1'b0}};
      rle_message_addr <= ADDR_ZERO;
      rle_message_size <= ADDR_ZERO;
      rle_rle_addr     <= ADDR_ZERO;
      busy             <= 1'b0;
      halted           <= 1'b0;
    end else begin
      rle_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fifo_not_empty_s) begin
            rle_message_addr <= head_s.msg_addr;
            rle_message_size <= head_s.msg_size;
            rle_rle_addr     <= head_s.rle_addr;
            busy             <= 1'b1;
            if (is_empty_job(head_s)) begin
              state_r      <= ST_REPORT;
              res_valid    <= 1'b1;
              res_rle_size <= ADDR_ZERO;
              res_err      <= 1'b0;
            end else begin
              state_r   <= ST_LAUNCH;
              rle_start <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: state_r <= ST_SETTLE;
        // rle_done still reflects the previous job here.
        ST_SETTLE: begin
          state_r <= ST_WAIT;
          wd_r    <= {WD_W{1'b0}};
        end
        ST_WAIT: begin
          if (rle_done) begin
            state_r      <= ST_REPORT;
            res_valid    <= 1'b1;
            res_rle_size <= rle_size;
            res_err      <= 1'b0;
          end else if (wd_r == WD_LAST) begin
            state_r      <= ST_REPORT;
            res_valid    <= 1'b1;
            res_rle_size <= ADDR_ZERO;
            res_err      <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1'b1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_seq   <= res_seq + 8'd1;
            if (res_err) begin
              state_r <= ST_HALT;
              halted  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: begin
          state_r   <= ST_IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rle_job_sched.md
RLE_JOB_SCHED -- requirements
Module: rle_job_sched

Interface
REQ-001 Parameter JOB_DEPTH, default 4, meaning job-queue entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 65536, meaning max cycles in WAIT before the job is declared hung.
REQ-003 The clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; also the engine's clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 job_valid  in  1  host offers a job descriptor.
REQ-007 job_ready  out  1  queue not full; a job is accepted when job_valid && job_ready.
REQ-008 job_msg_addr  in  32  plaintext start address.
REQ-009 job_msg_size  in  32  plaintext length in bytes.
REQ-010 job_rle_addr  in  32  compressed-output start address.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  host consumes the result when res_valid && res_ready.
REQ-013 res_rle_size  out  32  compressed length in bytes for the completed job.
REQ-014 res_err  out  1  result is a timeout result.
REQ-015 res_seq  out  8  sequence number of the job; wraps at 255->0.
REQ-016 rle_start  out  1  one-cycle start pulse to the engine.
REQ-017 rle_message_addr, rle_message_size, rle_rle_addr  out  32 each  engine job operands.
REQ-018 rle_done  in  1  engine level done; high while the engine is idle with the count matched.
REQ-019 rle_size  in  32  engine compressed length.
REQ-020 busy  out  1  high in any state except IDLE.
REQ-021 halted  out  1  high in HALT.

Function
REQ-022 The FSM SHALL have the states IDLE, LAUNCH, SETTLE, WAIT, REPORT and HALT.
REQ-023 IDLE: when the queue is non-empty, pop the head into the operand registers and go to LAUNCH; a zero-size job instead goes to REPORT with res_rle_size=0 and res_err=0, and the engine is never started.
REQ-024 LAUNCH: rle_start=1 for exactly this cycle, then go to SETTLE.
REQ-025 SETTLE: rle_done SHALL be ignored for one cycle, because it is stale from the previous job; then go to WAIT.
REQ-026 WAIT: on rle_done=1, capture rle_size into res_rle_size with res_err=0 and go to REPORT.
REQ-027 WAIT: the watchdog counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES-1 without rle_done, set res_err=1 and res_rle_size=0 and go to REPORT.
REQ-028 The operand outputs SHALL stay constant from LAUNCH until the first cycle of REPORT inclusive, because the engine compares its count against rle_message_size continuously.
REQ-029 REPORT: res_valid=1; on res_ready, res_seq increments and the FSM goes to IDLE, or to HALT when res_err=1.
REQ-030 res_rle_size, res_err and res_seq SHALL be held stable while res_valid=1 and res_ready=0.
REQ-031 HALT: no further launches occur; the queue still accepts jobs until full; only reset exits HALT.
REQ-032 Queue: FIFO order with a registered count; job_ready = (count < JOB_DEPTH).
REQ-033 Queue: a push and a pop in the same cycle with count==JOB_DEPTH SHALL be allowed, leaving the count unchanged.
REQ-034 Queue: a push with count==0 is poppable in IDLE no earlier than the next cycle.
REQ-035 Job-to-start latency SHALL be 2 cycles: a job accepted at cycle t into an empty queue with the FSM in IDLE gives rle_start=1 at t+2.
REQ-036 The result latency after rle_done SHALL be 1 cycle (res_valid=1 the cycle after rle_done is sampled in WAIT).

Reset
REQ-037 Reset SHALL force: state=IDLE, queue empty, job_ready=1, rle_start=0, res_valid=0, res_err=0, res_rle_size=0, res_seq=0, rle_message_addr=0, rle_message_size=0, rle_rle_addr=0, watchdog=0, busy=0, halted=0.
REQ-038 Reset mid-job SHALL drop all queued and in-flight jobs with no result emitted; the engine is reset by its own nreset, which is outside this block.

Structure
REQ-039 A shared package rle_pkg SHALL hold the FSM state enumeration, the 32-bit address/size width constant and the 8-bit sequence width constant.
REQ-040 The queue SHALL be one sub-module, rle_job_fifo, parameterised by JOB_DEPTH and a 96-bit entry width.

Verification
REQ-041 One job {0x0000,16,0x0100}; the engine model asserts done 20 cycles after the start pulse with rle_size=8 -> rle_start at t+2, res_valid with res_rle_size=8, res_err=0, res_seq=0.
REQ-042 Push 5 jobs back to back with JOB_DEPTH=4 -> job_ready=0 after the 4th push, the 5th is accepted after the first pop, and results arrive in push order with res_seq 0..4.
REQ-043 The engine model holds rle_done=1 continuously, as the stale level from the prior job -> the scheduler does not report before SETTLE ends, and the result comes no earlier than LAUNCH+3.
REQ-044 A job with job_msg_size=0 -> rle_start never pulses; res_valid the cycle after the pop with res_rle_size=0.
REQ-045 TIMEOUT_CYCLES=64 and the engine never asserts done -> res_err=1 at WAIT+64; after res_ready, halted=1 and no start pulse follows even with the queue non-empty.
REQ-046 Assert reset in WAIT with 2 jobs queued -> on the next cycle busy=0, res_valid=0, job_ready=1, and no further rle_start.
